// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   PS/2 keyboard receiver plus scan-code-set-2 decoder. Conditions the raw
//   PS/2 lines, deframes 11-bit frames and folds the E0/F0/E1 prefix bytes
//   into single key events for the arcade control mapper.
//
//   Optional feature: define PS2_PARITY_CHECK_EN to enforce odd parity. When
//   it is undefined, the parity bit is clocked in but ignored.
//
// Ports
//   clk          in   system clock (shared with the downstream mapper)
//   reset        in   synchronous, active-high
//   ps2_clk      in   raw PS/2 clock, asynchronous
//   ps2_data     in   raw PS/2 data, asynchronous
//   key_strobe   out  one-cycle pulse per decoded key event
//   key_pressed  out  1 = make, 0 = break; held until the next strobe
//   key_extended out  event was E0-prefixed; held until the next strobe
//   key_code     out  scan code without prefixes; held until the next strobe
//   frame_error  out  one-cycle pulse on a discarded frame
module ps2_scancode_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 64000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_error
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMO_LIMIT = TCW'(TIMEOUT_CYC);

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PARITY_IGNORE = 1'b0;
`else
    localparam logic PARITY_IGNORE = 1'b1;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers (idle-high lines preset to 1)
    // ------------------------------------------------------------------
    logic clk_s1, clk_s2, data_s1, data_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // ------------------------------------------------------------------
    // Clock filter: the filtered level flips only after FILTER_LEN
    // consecutive samples disagree with it. Data is captured alongside the
    // fall so the FSM sees the bit that was present at the edge.
    // ------------------------------------------------------------------
    logic           clk_filt;
    logic [FCW-1:0] filt_cnt;
    logic           fall;
    logic           fall_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt  <= 1'b1;
            filt_cnt  <= '0;
            fall      <= 1'b0;
            fall_data <= 1'b1;
        end else begin
            fall <= 1'b0;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt  <= clk_s2;
                filt_cnt  <= '0;
                fall      <= clk_filt;
                fall_data <= data_s2;
            end else begin
                filt_cnt <= filt_cnt + FCW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t         state, state_nx;
    logic [2:0]     bit_cnt, bit_cnt_nx;
    logic [7:0]     shift_q, shift_nx;
    logic           par_q, par_nx;
    logic [TCW-1:0] tmo_cnt;
    logic           timeout;
    logic           parity_ok;
    logic           byte_done;
    logic           frame_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shift_q <= shift_nx;
            par_q   <= par_nx;
        end
    end

    // Cleared in IDLE and on every fall; free-runs otherwise.
    always_ff @(posedge clk) begin
        if (reset || state == S_IDLE || fall) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TCW'(1);
        end
    end

    assign timeout   = (state != S_IDLE) && (tmo_cnt == TMO_LIMIT);
    assign parity_ok = (^{shift_q, par_q}) | PARITY_IGNORE;

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift_q;
        par_nx     = par_q;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        // A timeout takes priority over a coincident fall, which is dropped.
        if (timeout) begin
            state_nx  = S_IDLE;
            frame_bad = 1'b1;
        end else if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!fall_data) begin
                        state_nx   = S_DATA;
                        bit_cnt_nx = '0;
                    end
                end
                S_DATA: begin
                    shift_nx   = {fall_data, shift_q[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_nx   = fall_data;
                    state_nx = S_STOP;
                end
                S_STOP: begin
                    state_nx = S_IDLE;
                    if (fall_data && parity_ok) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte decoder and registered outputs
    // ------------------------------------------------------------------
    logic       ext_flag;
    logic       rel_flag;
    logic [2:0] skip_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= '0;
            frame_error  <= 1'b0;
            ext_flag     <= 1'b0;
            rel_flag     <= 1'b0;
            skip_cnt     <= '0;
        end else begin
            key_strobe  <= 1'b0;
            frame_error <= frame_bad;
            if (byte_done) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else begin
                    case (shift_q)
                        8'hE1: begin
                            // Remaining seven bytes of the Pause sequence.
                            skip_cnt <= 3'd7;
                            ext_flag <= 1'b0;
                            rel_flag <= 1'b0;
                        end
                        8'hE0: ext_flag <= 1'b1;
                        8'hF0: rel_flag <= 1'b1;
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                            ext_flag <= 1'b0;
                            rel_flag <= 1'b0;
                        end
                        default: begin
                            key_strobe   <= 1'b1;
                            key_code     <= shift_q;
                            key_pressed  <= ~rel_flag;
                            key_extended <= ext_flag;
                            ext_flag     <= 1'b0;
                            rel_flag     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

    localparam int unsigned TMO  = 2000;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       frame_error;

    int checks = 0;
    int errors = 0;

    int         n_strobe = 0;
    int         n_err = 0;
    logic [7:0] last_code = 8'h00;
    logic       last_pressed = 1'b0;
    logic       last_ext = 1'b0;

    ps2_scancode_rx #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_strobe  (key_strobe),
        .key_pressed (key_pressed),
        .key_extended(key_extended),
        .key_code    (key_code),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    // Event monitor, sampling on the inactive edge.
    always @(negedge clk) begin
        if (key_strobe) begin
            n_strobe     = n_strobe + 1;
            last_code    = key_code;
            last_pressed = key_pressed;
            last_ext     = key_extended;
        end
        if (frame_error) n_err = n_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of an 11-bit frame (start, 8 data LSB first,
    // parity, stop), optionally corrupting parity or the stop bit.
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int unsigned nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(40);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    initial begin
        int s0, e0;

        // Reset state
        cyc(5);
        @(negedge clk);
        check("rst_strobe", {31'd0, key_strobe}, 32'd0);
        check("rst_outputs", {21'd0, key_pressed, key_extended, key_code, frame_error}, 32'd0);
        reset = 1'b0;
        cyc(20);

        // Plain make code
        s0 = n_strobe; e0 = n_err;
        send(8'h1C);
        check("make_count", n_strobe - s0, 1);
        check("make_code", {24'd0, last_code}, 32'h1C);
        check("make_pressed", {31'd0, last_pressed}, 1);
        check("make_ext", {31'd0, last_ext}, 0);
        check("make_err", n_err - e0, 0);

        // Break: F0 alone gives nothing, then 1C is the release
        s0 = n_strobe;
        send(8'hF0);
        check("f0_nostrobe", n_strobe - s0, 0);
        send(8'h1C);
        check("brk_count", n_strobe - s0, 1);
        check("brk_code", {24'd0, last_code}, 32'h1C);
        check("brk_pressed", {31'd0, last_pressed}, 0);

        // Extended break, then plain make clears ext
        s0 = n_strobe;
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("ext_count", n_strobe - s0, 1);
        check("ext_code", {24'd0, last_code}, 32'h75);
        check("ext_flag", {31'd0, last_ext}, 1);
        check("ext_pressed", {31'd0, last_pressed}, 0);
        send(8'h6B);
        check("after_ext_code", {24'd0, last_code}, 32'h6B);
        check("after_ext_flag", {31'd0, last_ext}, 0);
        check("after_ext_pressed", {31'd0, last_pressed}, 1);

        // Wrong parity bit
        s0 = n_strobe; e0 = n_err;
        send_frame(8'h29, 1'b1, 1'b0, 11);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err", n_err - e0, 1);
        check("par_nostrobe", n_strobe - s0, 0);
`else
        check("par_err", n_err - e0, 0);
        check("par_strobe", n_strobe - s0, 1);
        check("par_code", {24'd0, last_code}, 32'h29);
`endif

        // Partial frame then stall past the timeout
        s0 = n_strobe; e0 = n_err;
        send_frame(8'h33, 1'b0, 1'b0, 4);
        cyc(TMO + 10);
        check("tmo_err", n_err - e0, 1);
        check("tmo_nostrobe", n_strobe - s0, 0);
        send(8'h05);
        check("tmo_recover_count", n_strobe - s0, 1);
        check("tmo_recover_code", {24'd0, last_code}, 32'h05);
        check("tmo_err_once", n_err - e0, 1);

        // Bad stop bit: error, prefix survives it
        s0 = n_strobe; e0 = n_err;
        send(8'hE0);
        send_frame(8'h12, 1'b0, 1'b1, 11);
        check("stop_err", n_err - e0, 1);
        check("stop_nostrobe", n_strobe - s0, 0);
        send(8'h74);
        check("persist_code", {24'd0, last_code}, 32'h74);
        check("persist_ext", {31'd0, last_ext}, 1);
        check("persist_pressed", {31'd0, last_pressed}, 1);

        // Discard byte clears a pending release
        s0 = n_strobe;
        send(8'hF0);
        send(8'hAA);
        send(8'h1C);
        check("discard_count", n_strobe - s0, 1);
        check("discard_pressed", {31'd0, last_pressed}, 1);

        // Short glitch on ps2_clk is filtered out
        s0 = n_strobe;
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cyc(40);
        send(8'h1B);
        check("glitch_count", n_strobe - s0, 1);
        check("glitch_code", {24'd0, last_code}, 32'h1B);

        // Pause sequence swallowed entirely
        s0 = n_strobe; e0 = n_err;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause_nostrobe", n_strobe - s0, 0);
        send(8'h05);
        check("pause_after_count", n_strobe - s0, 1);
        check("pause_after_code", {24'd0, last_code}, 32'h05);
        check("pause_after_pressed", {31'd0, last_pressed}, 1);
        check("pause_err", n_err - e0, 0);

        // Reset mid-frame
        s0 = n_strobe; e0 = n_err;
        send_frame(8'h4D, 1'b0, 1'b0, 5);
        reset = 1'b1;
        cyc(3);
        @(negedge clk);
        check("midrst_outputs", {22'd0, key_strobe, key_pressed, key_extended, key_code}, 32'd0);
        check("midrst_ferr", {31'd0, frame_error}, 0);
        reset = 1'b0;
        cyc(20);
        send(8'h1C);
        check("midrst_count", n_strobe - s0, 1);
        check("midrst_code", {24'd0, last_code}, 32'h1C);
        check("midrst_pressed", {31'd0, last_pressed}, 1);
        check("midrst_err", n_err - e0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
